// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial subnode link: word-derived widths, FSM states, counter sizing.
// Optional feature macro used by this link: SERIAL_MASTER_TIMEOUT_EN.
package serial_link_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NB_DEF = 4;
  localparam int unsigned NK_DEF = 8;
  localparam int unsigned MW_DEF = WORD_W * NB_DEF;
  localparam int unsigned KW_DEF = WORD_W * NK_DEF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_MSG  = 3'd1,
    SEND_KEY  = 3'd2,
    WAIT_RESP = 3'd3,
    RECV      = 3'd4
  } state_e;

  // Bits needed to count from 0 up to and including max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_master_node_if.sv
// Controller/subnode-facing signal bundle of serial_master_node.
// timeout_err exists only when SERIAL_MASTER_TIMEOUT_EN is defined.
interface serial_master_node_if #(
  parameter int unsigned MW = serial_link_pkg::MW_DEF,
  parameter int unsigned KW = serial_link_pkg::KW_DEF
);

  logic          start;
  logic [MW-1:0] msg_in;
  logic [KW-1:0] key_in;
  logic          busy;
  logic          cs;
  logic          in_valid;
  logic          sdo;
  logic          sdi;
  logic          out_valid;
  logic [MW-1:0] result;
  logic          done;
`ifdef SERIAL_MASTER_TIMEOUT_EN
  logic          timeout_err;
`endif

  modport master (
    input  start, msg_in, key_in, sdi, out_valid,
    output busy, cs, in_valid, sdo, result, done
`ifdef SERIAL_MASTER_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport slave (
    output start, msg_in, key_in, sdi, out_valid,
    input  busy, cs, in_valid, sdo, result, done
`ifdef SERIAL_MASTER_TIMEOUT_EN
    , input timeout_err
`endif
  );

endinterface

// File: rtl/serial_shift_rx.sv
// Serial-in parallel-out receiver: MSB-first frame of W bits, holds the last completed frame in data.
// Only W-1 bits need shifting; the final bit is merged directly into data on completion.
module serial_shift_rx import serial_link_pkg::*; #(
  parameter int unsigned W  = MW_DEF,
  parameter int unsigned CW = cnt_w(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          din,
  output logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [W-2:0] sh_q;
  logic         last;

  assign last = (count == CW'(W - 1));

  // clr restarts a frame but keeps the last completed word visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      count <= '0;
      full  <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      sh_q  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (en && !full) begin
      sh_q  <= {sh_q[W-3:0], din};
      count <= count + CW'(1);
      if (last) begin
        data <= {sh_q, din};
        full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_master_node.sv
// Master end of the serial subnode link: shifts msg then key out MSB-first, collects the MW-bit reply.
// Define SERIAL_MASTER_TIMEOUT_EN to bound the response wait and add timeout_err.
module serial_master_node import serial_link_pkg::*; #(
  parameter int unsigned NB = NB_DEF,
  parameter int unsigned NK = NK_DEF
`ifdef SERIAL_MASTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input logic                  in_clk,
  input logic                  rst,
  serial_master_node_if.master bus
);

  localparam int unsigned MW  = WORD_W * NB;
  localparam int unsigned KW  = WORD_W * NK;
  localparam int unsigned TW  = MW + KW;
  localparam int unsigned BCW = cnt_w(TW);
  localparam int unsigned RCW = cnt_w(MW);
`ifdef SERIAL_MASTER_TIMEOUT_EN
  localparam int unsigned TCW = cnt_w(TIMEOUT_CYCLES);
`endif

  state_e          state_q, state_d;
  logic [TW-1:0]   sr_q, sr_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic            cs_q, cs_d;
  logic            in_valid_q, in_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rx_clr_c, rx_en_c;
  logic [MW-1:0]   rx_data;
  logic [RCW-1:0]  rx_count;
  logic            rx_full;
`ifdef SERIAL_MASTER_TIMEOUT_EN
  logic [TCW-1:0]  to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  serial_shift_rx #(.W(MW), .CW(RCW)) u_rx (
    .clk   (in_clk),
    .rst   (rst),
    .clr   (rx_clr_c),
    .en    (rx_en_c),
    .din   (bus.sdi),
    .data  (rx_data),
    .count (rx_count),
    .full  (rx_full)
  );

  // Shifting zeros in leaves sr empty after the last bit, so sdo idles low.
  assign bus.sdo      = sr_q[TW-1];
  assign bus.cs       = cs_q;
  assign bus.in_valid = in_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = rx_data;
`ifdef SERIAL_MASTER_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    cs_d       = cs_q;
    in_valid_d = in_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_clr_c   = 1'b0;
    rx_en_c    = 1'b0;
`ifdef SERIAL_MASTER_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        cs_d       = 1'b1;
        in_valid_d = 1'b0;
        busy_d     = 1'b0;
        // A start coinciding with the done pulse is dropped.
        if (bus.start && !done_q) begin
          state_d    = SEND_MSG;
          sr_d       = {bus.msg_in, bus.key_in};
          bit_cnt_d  = '0;
          cs_d       = 1'b0;
          in_valid_d = 1'b1;
          busy_d     = 1'b1;
          rx_clr_c   = 1'b1;
`ifdef SERIAL_MASTER_TIMEOUT_EN
          to_cnt_d      = '0;
          timeout_err_d = 1'b0;
`endif
        end
      end

      SEND_MSG, SEND_KEY: begin
        sr_d      = {sr_q[TW-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BCW'(1);
        if (bit_cnt_q == BCW'(TW - 1)) begin
          state_d    = WAIT_RESP;
          in_valid_d = 1'b0;
        end else if (bit_cnt_q == BCW'(MW - 1)) begin
          state_d = SEND_KEY;
        end
      end

      WAIT_RESP, RECV: begin
        if (bus.out_valid && !rx_full) begin
          rx_en_c = 1'b1;
          state_d = RECV;
`ifdef SERIAL_MASTER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (rx_count == RCW'(MW - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cs_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
`ifdef SERIAL_MASTER_TIMEOUT_EN
        else if (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = IDLE;
          cs_d          = 1'b1;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
          to_cnt_d      = '0;
        end else begin
          to_cnt_d = to_cnt_q + TCW'(1);
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      cs_q       <= 1'b1;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SERIAL_MASTER_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      cs_q       <= cs_d;
      in_valid_q <= in_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SERIAL_MASTER_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_master_node.sv
// Directed bench for serial_master_node with a behavioural subnode replying a fixed block.
// With SERIAL_MASTER_TIMEOUT_EN the DUT is built with TIMEOUT_CYCLES=16 and the timeout path is exercised.
module tb_serial_master_node;

  localparam int unsigned MW = 128;
  localparam int unsigned KW = 256;
  localparam int unsigned TW = MW + KW;
  localparam int RESP_DELAY  = 5;
  // done is seen 1 + 384 + 5 + 127 edges after the accepting edge.
  localparam int LAT_NOM     = 517;
  localparam int PAUSE_LEN   = 3;

  localparam logic [MW-1:0] MSG_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [KW-1:0] KEY_A = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [MW-1:0] MSG_B = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [KW-1:0] KEY_B = 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;
  localparam logic [MW-1:0] RESP  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  bit   model_en;
  int   pause_at;

  logic [MW-1:0] m_sr;
  int   m_idle, m_bit, m_hold;
  bit   m_armed;

  logic [TW-1:0] stream;
  int   iv_cnt, cs_err, done_cnt;
  bit   prev_iv;

  serial_master_node_if #(.MW(MW), .KW(KW)) bus ();

  serial_master_node #(
    .NB(4),
    .NK(8)
`ifdef SERIAL_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .in_clk (clk),
    .rst    (rst),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_txn(input logic [MW-1:0] m, input logic [KW-1:0] k);
    @(negedge clk);
    bus.msg_in = m;
    bus.key_in = k;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check_eq("done_seen", TW'(lat > 0), TW'(1));
  endtask

  // Subnode model: falling-edge side, replies RESP after RESP_DELAY idle cycles.
  initial begin
    bus.out_valid = 1'b0;
    bus.sdi       = 1'b0;
    m_armed = 1'b0; m_idle = 0; m_bit = 0; m_hold = 0; m_sr = '0;
    forever begin
      @(negedge clk);
      if (rst || bus.cs) begin
        bus.out_valid = 1'b0;
        bus.sdi       = 1'b0;
        m_armed = 1'b0; m_idle = 0; m_bit = 0; m_hold = 0;
      end else if (bus.in_valid) begin
        m_armed = 1'b1; m_idle = 0; m_bit = 0; m_hold = 0;
        m_sr    = RESP;
      end else if (m_armed && model_en) begin
        bus.out_valid = 1'b0;
        if (m_idle < RESP_DELAY) begin
          m_idle++;
        end else if (m_bit == pause_at && m_hold < PAUSE_LEN) begin
          m_hold++;
        end else if (m_bit < int'(MW)) begin
          bus.out_valid = 1'b1;
          bus.sdi       = m_sr[MW-1];
          m_sr          = {m_sr[MW-2:0], 1'b0};
          m_bit++;
        end
      end
    end
  end

  // Stream monitor: captures sdo while in_valid, counts cs-high-while-busy and done pulses.
  initial begin
    stream = '0; iv_cnt = 0; cs_err = 0; done_cnt = 0; prev_iv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.in_valid) begin
        if (!prev_iv) begin
          stream = '0; iv_cnt = 0; cs_err = 0;
        end
        stream = {stream[TW-2:0], bus.sdo};
        iv_cnt++;
      end
      if (bus.busy && bus.cs) cs_err++;
      if (bus.done) done_cnt++;
      prev_iv = bus.in_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int d0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.msg_in = '0;
    bus.key_in = '0;
    model_en   = 1'b1;
    pause_at   = -1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs",       TW'(bus.cs),       TW'(1));
    check_eq("rst_in_valid", TW'(bus.in_valid), TW'(0));
    check_eq("rst_sdo",      TW'(bus.sdo),      TW'(0));
    check_eq("rst_busy",     TW'(bus.busy),     TW'(0));
    check_eq("rst_done",     TW'(bus.done),     TW'(0));
    check_eq("rst_result",   TW'(bus.result),   TW'(0));
`ifdef SERIAL_MASTER_TIMEOUT_EN
    check_eq("rst_timeout",  TW'(bus.timeout_err), TW'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    // Basic loopback.
    d0 = done_cnt;
    start_txn(MSG_A, KEY_A);
    check_eq("t1_busy",     TW'(bus.busy),     TW'(1));
    check_eq("t1_cs",       TW'(bus.cs),       TW'(0));
    check_eq("t1_in_valid", TW'(bus.in_valid), TW'(1));
    check_eq("t1_first",    TW'(bus.sdo),      TW'(MSG_A[MW-1]));
    wait_done(1000, lat);
    check_eq("t1_lat",       TW'(lat),        TW'(LAT_NOM));
    check_eq("t1_result",    TW'(bus.result), TW'(RESP));
    check_eq("t1_done_cs",   TW'(bus.cs),     TW'(1));
    check_eq("t1_done_busy", TW'(bus.busy),   TW'(0));
    @(posedge clk);
    #1;
    check_eq("t1_done_once", TW'(bus.done),   TW'(0));
    check_eq("t1_busy_next", TW'(bus.busy),   TW'(0));
    check_eq("t1_stream",    stream,          {MSG_A, KEY_A});
    check_eq("t1_iv_cnt",    TW'(iv_cnt),     TW'(TW));
    check_eq("t1_cs_low",    TW'(cs_err),     TW'(0));
    check_eq("t1_done_cnt",  TW'(done_cnt),   TW'(d0 + 1));

    // out_valid gap of 3 cycles after 60 result bits.
    pause_at = 60;
    start_txn(MSG_B, KEY_B);
    check_eq("t2_first", TW'(bus.sdo), TW'(MSG_B[MW-1]));
    wait_done(1000, lat);
    check_eq("t2_lat",    TW'(lat),        TW'(LAT_NOM + PAUSE_LEN));
    check_eq("t2_result", TW'(bus.result), TW'(RESP));
    @(posedge clk);
    #1;
    check_eq("t2_stream", stream,          {MSG_B, KEY_B});
    check_eq("t2_iv_cnt", TW'(iv_cnt),     TW'(TW));
    check_eq("t2_cs_low", TW'(cs_err),     TW'(0));
    pause_at = -1;

    // Reset at key bit 200.
    d0 = done_cnt;
    start_txn(MSG_A, KEY_A);
    repeat (MW + 200) @(posedge clk);
    #1;
    check_eq("t3_key_bit", TW'(bus.sdo), TW'(KEY_A[KW-1-200]));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t3_cs",       TW'(bus.cs),       TW'(1));
    check_eq("t3_in_valid", TW'(bus.in_valid), TW'(0));
    check_eq("t3_busy",     TW'(bus.busy),     TW'(0));
    check_eq("t3_sdo",      TW'(bus.sdo),      TW'(0));
    check_eq("t3_result",   TW'(bus.result),   TW'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t3_no_done", TW'(done_cnt), TW'(d0));
    start_txn(MSG_A, KEY_A);
    wait_done(1000, lat);
    check_eq("t3_lat",    TW'(lat),        TW'(LAT_NOM));
    check_eq("t3_result", TW'(bus.result), TW'(RESP));
    @(posedge clk);
    #1;
    check_eq("t3_stream", stream, {MSG_A, KEY_A});

    // start held high across a whole transaction.
    d0 = done_cnt;
    @(negedge clk);
    bus.msg_in = MSG_B;
    bus.key_in = KEY_A;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t4_busy", TW'(bus.busy), TW'(1));
    wait_done(1000, lat);
    check_eq("t4_lat1", TW'(lat), TW'(LAT_NOM));
    @(posedge clk);
    #1;
    check_eq("t4_ignore_done_cycle", TW'(bus.busy), TW'(0));
    @(posedge clk);
    #1;
    check_eq("t4_second_start", TW'(bus.busy), TW'(1));
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1000, lat);
    check_eq("t4_lat2",   TW'(lat),        TW'(LAT_NOM));
    check_eq("t4_result", TW'(bus.result), TW'(RESP));
    @(posedge clk);
    #1;
    check_eq("t4_done_cnt", TW'(done_cnt), TW'(d0 + 2));
    check_eq("t4_stream",   stream,        {MSG_B, KEY_A});

`ifdef SERIAL_MASTER_TIMEOUT_EN
    // Silent subnode: timeout 16 cycles into WAIT_RESP (edge 384 + 16).
    model_en = 1'b0;
    d0 = done_cnt;
    start_txn(MSG_A, KEY_A);
    lat = -1;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk);
      #1;
      if (bus.timeout_err) begin
        lat = i;
        break;
      end
    end
    check_eq("t5_lat",    TW'(lat),        TW'(TW + 16));
    check_eq("t5_cs",     TW'(bus.cs),     TW'(1));
    check_eq("t5_busy",   TW'(bus.busy),   TW'(0));
    check_eq("t5_result", TW'(bus.result), TW'(RESP));
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_sticky",  TW'(bus.timeout_err), TW'(1));
    check_eq("t5_no_done", TW'(done_cnt),        TW'(d0));
    model_en = 1'b1;
    start_txn(MSG_B, KEY_B);
    check_eq("t5_clear", TW'(bus.timeout_err), TW'(0));
    wait_done(1000, lat);
    check_eq("t5_result2", TW'(bus.result), TW'(RESP));
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_master_node.md
Name: serial_master_node

Overview:
- Master-world end of the serial subnode link. Drives the message and key bit-serially into a subnode (cs, in_valid, serial data).
- Collects the subnode's serial result (out_valid, serial data) and presents it in parallel with a done pulse.
- Sits between the top-level controller and the subnode wrapping the Enc/Dec core.
- Subnode samples on the falling edge; this block launches and samples on the rising edge.

Parameters:
- NK, 8, key length in 32-bit words; KW = 32*NK bits.
- NB, 4, block width in 32-bit words; MW = 32*NB bits.
- TIMEOUT_CYCLES, 1024, response wait limit (used only with SERIAL_MASTER_TIMEOUT_EN).

Ports:
- in_clk  in  1  single clock, shared with the subnode.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a transaction; sampled only in IDLE.
- msg_in  in  MW  message to send; latched on accepted start.
- key_in  in  KW  key to send; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- cs  out  1  active-low subnode select.
- in_valid  out  1  high while msg/key bits are on sdo.
- sdo  out  1  serial data to the subnode's sdi.
- sdi  in  1  serial result from the subnode's sdo.
- out_valid  in  1  subnode result-bit qualifier.
- result  out  MW  received result, MSB = first bit received.
- done  out  1  one-cycle pulse when result is updated.
- timeout_err  out  1  present only with SERIAL_MASTER_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - Outputs: cs=1, in_valid=0, sdo=0, busy=0, done=0, result=0, timeout_err=0.
  - State returns to IDLE; all counters return to 0.
  - Reset mid-transaction aborts immediately. cs=1 also clears the subnode.
- States: IDLE, SEND_MSG, SEND_KEY, WAIT_RESP, RECV.
- IDLE:
  - cs=1, in_valid=0.
  - On start=1: latch {msg_in, key_in} into a (MW+KW)-bit shift register and go to SEND_MSG.
- SEND_MSG / SEND_KEY:
  - cs=0 and in_valid=1 for exactly MW+KW consecutive cycles.
  - sdo = shift register MSB; shift left one bit per cycle.
  - Order: msg bit MW-1 first, down to msg bit 0, then key bit KW-1 down to key bit 0.
  - First bit appears the cycle after start is accepted.
  - A bit counter (width clog2(MW+KW+1)) splits the two phases at count MW.
- WAIT_RESP:
  - cs=0, in_valid=0, sdo=0.
  - Wait for out_valid=1. Without the timeout feature the wait is unbounded.
- RECV (entered on the first posedge with out_valid=1, and that bit is captured):
  - On each posedge with out_valid=1, shift sdi into the LSB of the receive register and increment the receive counter.
  - out_valid=0 mid-frame: hold the count, do not sample, stay in RECV.
  - After the MW-th sample:
    - Copy the receive register to result and pulse done=1 for one cycle.
    - Drive cs=1, busy=0 and go to IDLE in the same cycle.
- Concurrent events:
  - start while busy is ignored.
  - start in the same cycle as done is ignored (IDLE is reached after done).
  - result holds its value until the next done or reset.
- Total latency = 1 + MW + KW + subnode response delay + MW cycles.

Optional Feature:
- Macro: SERIAL_MASTER_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT_RESP and RECV and clears on each sampled bit.
  - On reaching TIMEOUT_CYCLES: drive cs=1, set timeout_err=1, return to IDLE, leave result unchanged, no done pulse.
  - timeout_err clears on the next accepted start or on reset.
- Without the macro: no timeout_err port, no counter, the wait is unbounded.

Decomposition:
- Shared package serial_link_pkg:
  - State encoding (localparams IDLE..RECV).
  - Widths MW/KW derived from NB/NK.
  - Counter width function.
- Sub-module serial_shift_rx: MW-bit SIPO with enable, count and full flag. Used here for RECV and reusable by the subnode.
- The PISO stays inline.

Test Plan:
- Loopback with a subnode model (NB=4, NK=8); start with msg=128'h00112233445566778899AABBCCDDEEFF, key=256'h000102…1F.
  - sdo bit stream equals msg then key, MSB first; in_valid high for exactly 384 cycles; cs low throughout.
- Model returns 128'h69C4E0D86A7B0430D8CDB78070B4C55A after 5 idle cycles.
  - result matches; done pulses exactly once; cs=1 in the done cycle; busy=0 the next cycle.
- out_valid dropped for 3 cycles mid-response, after bit 60 of 128.
  - Hold with no extra samples; result is still correct; done is delayed by 3 cycles.
- rst=1 at bit 200 of SEND_KEY.
  - Next cycle: cs=1, in_valid=0, busy=0, result unchanged from reset value 0.
  - A new start then completes normally.
- start asserted continuously during a transaction.
  - Exactly one transaction runs; a second starts only after IDLE is re-entered.
- SERIAL_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, model never asserts out_valid.
  - timeout_err=1 and cs=1 after 16 WAIT_RESP cycles; no done pulse.
  - The next start clears timeout_err.
